// File: rtl/sumador_debounce_bcd.sv
// sumador_debounce_bcd: button-driven up-counter with debounce and BCD display feed.
//
// A raw, bouncy, active-low push button is synchronized and debounced. Each clean press
// increments an N-bit count. After reset the count is loaded once from the switches.
// The count is then converted to two BCD digits by a sequential double-dabble engine.
//
// Ports:
//   clk        system clock; all state changes on the rising edge except reset
//   btn_rst    asynchronous active-low reset
//   btn_add    raw increment button, active-low, asynchronous to clk, bouncy
//   data_in    start value from the switches, sampled only in the load state
//   count      current binary count
//   bcd_out    [7:4] tens digit, [3:0] units digit of count
//   bcd_valid  high when bcd_out matches the current count
module sumador_debounce_bcd #(
    parameter int unsigned N          = 6,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter bit          WRAP       = 1'b1
) (
    input  logic         clk,
    input  logic         btn_rst,
    input  logic         btn_add,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] count,
    output logic [7:0]   bcd_out,
    output logic         bcd_valid
);

    localparam int unsigned    DebW     = $clog2(DEB_CYCLES);
    localparam logic [DebW-1:0] DebMax  = DebW'(DEB_CYCLES - 1);
    localparam logic [N-1:0]   CntMax   = '1;
    localparam int unsigned    ScrW     = 8 + N;
    localparam logic [2:0]     IterLast = 3'(N - 1);

    typedef enum logic {StLoad, StRun}   ctrl_e;
    typedef enum logic {StIdle, StShift} conv_e;

    // Synchronizer and debounce
    logic            sync1_q, sync1_d;
    logic            sync_q, sync_d;
    logic            btn_stable_q, btn_stable_d;
    logic            stable_prev_q, stable_prev_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic            add_pulse;

    // Control
    ctrl_e           ctrl_q, ctrl_d;
    logic [N-1:0]    count_q, count_d;
    logic            start;

    // Converter
    conv_e           conv_q, conv_d;
    logic [ScrW-1:0] scratch_q, scratch_d;
    logic [2:0]      iter_q, iter_d;
    logic [7:0]      bcd_out_q, bcd_out_d;
    logic            bcd_valid_q, bcd_valid_d;
    logic [ScrW-1:0] adj;
    logic [ScrW-1:0] shifted;

    assign sync1_d       = btn_add;
    assign sync_d        = sync1_q;
    assign stable_prev_d = btn_stable_q;

    // A new level is accepted only after DEB_CYCLES consecutive cycles away from the
    // stable level; any return to the stable level restarts the count.
    always_comb begin
        btn_stable_d = btn_stable_q;
        deb_cnt_d    = '0;
        if (sync_q != btn_stable_q) begin
            if (deb_cnt_q == DebMax) begin
                btn_stable_d = sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Press is the falling edge of the debounced level; release gives no pulse.
    assign add_pulse = stable_prev_q & ~btn_stable_q;

    always_comb begin
        ctrl_d  = ctrl_q;
        count_d = count_q;
        start   = 1'b0;
        unique case (ctrl_q)
            StLoad: begin
                count_d = data_in;
                start   = 1'b1;
                ctrl_d  = StRun;
            end
            StRun: begin
                if (add_pulse) begin
                    if (count_q != CntMax) begin
                        count_d = count_q + 1'b1;
                        start   = 1'b1;
                    end else if (WRAP) begin
                        count_d = '0;
                        start   = 1'b1;
                    end else begin
                        // Saturated: reconvert only if a display update is still pending.
                        start = ~bcd_valid_q;
                    end
                end
            end
            default: ctrl_d = StLoad;
        endcase
    end

    // Double dabble: scratch is {tens, units, binary}; each step adds 3 to any digit >= 5
    // and then shifts left, so after N steps the digits hold the BCD result.
    always_comb begin
        adj = scratch_q;
        if (adj[N+3:N] >= 4'd5) begin
            adj[N+3:N] = adj[N+3:N] + 4'd3;
        end
        if (adj[N+7:N+4] >= 4'd5) begin
            adj[N+7:N+4] = adj[N+7:N+4] + 4'd3;
        end
        shifted = {adj[ScrW-2:0], 1'b0};
    end

    always_comb begin
        conv_d      = conv_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        bcd_out_d   = bcd_out_q;
        bcd_valid_d = bcd_valid_q;
        if (start) begin
            // A restart during SHIFT drops the old operand so no stale result appears.
            scratch_d   = {8'h00, count_d};
            iter_d      = '0;
            bcd_valid_d = 1'b0;
            conv_d      = StShift;
        end else if (conv_q == StShift) begin
            scratch_d = shifted;
            iter_d    = iter_q + 3'd1;
            if (iter_q == IterLast) begin
                bcd_out_d   = shifted[ScrW-1:N];
                bcd_valid_d = 1'b1;
                conv_d      = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge btn_rst) begin
        if (!btn_rst) begin
            sync1_q       <= 1'b1;
            sync_q        <= 1'b1;
            btn_stable_q  <= 1'b1;
            stable_prev_q <= 1'b1;
            deb_cnt_q     <= '0;
            ctrl_q        <= StLoad;
            count_q       <= '0;
            conv_q        <= StIdle;
            scratch_q     <= '0;
            iter_q        <= '0;
            bcd_out_q     <= 8'h00;
            bcd_valid_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync_q        <= sync_d;
            btn_stable_q  <= btn_stable_d;
            stable_prev_q <= stable_prev_d;
            deb_cnt_q     <= deb_cnt_d;
            ctrl_q        <= ctrl_d;
            count_q       <= count_d;
            conv_q        <= conv_d;
            scratch_q     <= scratch_d;
            iter_q        <= iter_d;
            bcd_out_q     <= bcd_out_d;
            bcd_valid_q   <= bcd_valid_d;
        end
    end

    assign count     = count_q;
    assign bcd_out   = bcd_out_q;
    assign bcd_valid = bcd_valid_q;

endmodule

// File: doc/sumador_debounce_bcd.md
Name: sumador_debounce_bcd

Overview:
- Clocked up-counter: the incrementing counterpart of the board's button-driven decrementer.
- Takes a raw, bouncy, active-low board button and synchronizes and debounces it.
- Increments an N-bit count on each clean press, loading its start value from the switches after reset.
- Converts the count to two BCD digits with a sequential double-dabble engine that feeds the existing 7-segment decoder.

Parameters:
- N, 6, counter width; legal range 1..6, so the BCD result always fits in two digits.
- DEB_CYCLES, 500000, number of consecutive clk cycles the synchronized button must stay at a new level before it is accepted (10 ms at 50 MHz); minimum 2.
- WRAP, 1, overflow policy: 1 = count wraps to 0 after 2^N-1; 0 = count saturates at 2^N-1.

Ports:
- clk  input  1  system clock (50 MHz on board); all state changes on rising edge except reset.
- btn_rst  input  1  reset, asynchronous, active-low.
- btn_add  input  1  raw increment button, active-low, asynchronous to clk, bouncy.
- data_in  input  N  start value from switches; sampled only in LOAD.
- count  output  N  current binary count.
- bcd_out  output  8  [7:4] tens digit, [3:0] units digit of count.
- bcd_valid  output  1  high when bcd_out matches the current count.

Behaviour:
Reset:
- btn_rst low forces immediately: sync FFs = 1, btn_stable = 1, debounce counter = 0, count = 0, bcd_out = 8'h00, bcd_valid = 0, control FSM = LOAD, converter = IDLE.
- Reset may assert at any time, including mid-conversion or mid-debounce; all in-flight work is discarded.

Synchronizer:
- Two flops on btn_add, idle value 1.
- sync_q is btn_add delayed by 2 clk cycles.

Debounce:
- If sync_q == btn_stable, the counter clears to 0.
- Otherwise the counter increments each cycle. When it reaches DEB_CYCLES-1 with sync_q still different, btn_stable <= sync_q and the counter clears.
- Any bounce back to the stable level before that point restarts the count from 0.

Edge detect:
- add_pulse is high for exactly one cycle when btn_stable goes 1 -> 0.
- The release (0 -> 1) produces no pulse.
- Holding the button produces exactly one increment.

Control FSM, states LOAD and RUN:
- LOAD: on the first rising clk edge after btn_rst deasserts, count <= data_in, start conversion, go to RUN.
- RUN: on add_pulse, count <= count+1. At 2^N-1, count becomes 0 if WRAP=1, or holds if WRAP=0.
- Changing data_in in RUN has no effect. Only a new reset reloads it.

BCD converter, states IDLE and SHIFT:
- A start request occurs on every count update, and on the saturate-hold case only if bcd_valid is low.
- On start: capture count, clear the scratch register, bcd_valid <= 0, enter SHIFT.
- SHIFT runs N iterations, one per cycle: add 3 to each digit >= 5, then shift left one bit.
- After the Nth iteration: bcd_out <= result, bcd_valid <= 1, return to IDLE.
- Latency from count update to bcd_valid = N cycles.
- bcd_out holds its previous value while bcd_valid = 0.
- A start request during SHIFT aborts and restarts with the new count; it never produces a stale result.

Simultaneous events:
- btn_rst has priority over everything.
- An add_pulse in the same cycle as LOAD cannot occur, because btn_stable resets to 1.

Worst-case press-to-display latency: 2 (sync) + DEB_CYCLES (debounce) + 1 (edge/count) + N (convert) cycles.

Test Plan (bench uses DEB_CYCLES=4, N=6):
1. Reset with data_in=6'd17, release btn_rst -> next edge count=17; 6 cycles later bcd_out=8'h17, bcd_valid=1.
2. Clean press (btn_add low for 20 cycles, then high) -> count 17 -> 18 exactly once, bcd_out=8'h18; the release causes no change.
3. Bouncy press: low 2 cycles, high 1, low 2, high 1, then low 10 -> exactly one increment; the glitches shorter than 4 cycles are ignored.
4. Overflow from data_in=63:
   - WRAP=1, one press -> count=0, bcd_out=8'h00.
   - WRAP=0, one press -> count stays 63, bcd_out=8'h63.
5. Assert btn_rst mid-conversion (bcd_valid=0) with data_in changed to 42 -> outputs go to 0 / 8'h00 / 0 immediately; after release count=42, bcd_out=8'h42.
6. Change data_in from 5 to 50 while in RUN with no press -> count and bcd_out unchanged (5, 8'h05).
